// File: rtl/reg_writeback_ctrl_if.sv
// Writeback request channel into reg_writeback_ctrl.
// Ports: valid/addr/data (master->slave), ready (slave->master).
interface reg_writeback_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output addr,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  data,
        output ready
    );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Writeback buffer in front of the register file write port: in-order FIFO
// drained one entry per cycle into a registered rf_* output stage.
// Ports: clk, rst (sync, active-low), wb (request channel, slave),
//   stall (hold drain), rf_addr/rf_write_en/rf_write_data (write port),
//   pending_mask (in-flight dest regs), count (occupancy), idle,
//   fwd_addr/fwd_hit/fwd_data (forwarding lookup).
// Optional: define REG_WB_FORWARD_EN to build the forwarding compare logic;
//   otherwise fwd_hit/fwd_data are tied to zero.
module reg_writeback_ctrl #(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = 4,
    parameter  int DATA_W = 32,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1,
    localparam int NREG   = 1 << ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    reg_writeback_ctrl_if.slave wb,
    input  logic                stall,
    output logic [ADDR_W-1:0]   rf_addr,
    output logic                rf_write_en,
    output logic [DATA_W-1:0]   rf_write_data,
    output logic [NREG-1:0]     pending_mask,
    output logic [CNT_W-1:0]    count,
    output logic                idle,
    input  logic [ADDR_W-1:0]   fwd_addr,
    output logic                fwd_hit,
    output logic [DATA_W-1:0]   fwd_data
);

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // No pass-through when full: a pop in the same cycle does not free a slot.
    assign wb.ready = rst && (count != CNT_W'(DEPTH));
    assign push     = wb.valid && wb.ready;
    assign pop      = (count != '0) && !stall;
    assign idle     = (count == '0) && !rf_write_en;

    // Payload storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= wb.addr;
            mem_data[wr_ptr] <= wb.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rf_write_en   <= 1'b0;
            rf_addr       <= '0;
            rf_write_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                rf_addr       <= mem_addr[rd_ptr];
                rf_write_data <= mem_data[rd_ptr];
                rf_write_en   <= 1'b1;
            end else begin
                rf_write_en   <= 1'b0;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry k positions past the head is valid when k < count.
    always_comb begin
        pending_mask = '0;
        if (rf_write_en) begin
            pending_mask[rf_addr] = 1'b1;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count) begin
                pending_mask[mem_addr[rd_ptr + PTR_W'(k)]] = 1'b1;
            end
        end
    end

`ifdef REG_WB_FORWARD_EN
    // Scan oldest to youngest so the last match (newest data) wins;
    // the output stage is older than every FIFO entry.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (rf_write_en && (rf_addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = rf_write_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count) &&
                (mem_addr[rd_ptr + PTR_W'(k)] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data[rd_ptr + PTR_W'(k)];
            end
        end
    end
`else
    logic unused_fwd;

    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
    assign unused_fwd = ^fwd_addr;
`endif

endmodule
